// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one read outstanding, and hands {pc, inst} to decode over valid/ready.
// A flush redirects on the next cycle from ST_HOLD; from ST_AR/ST_R it takes effect once the in-flight response has been discarded.
module ysyx_23060203_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  typedef enum logic [1:0] {
    ST_AR   = 2'd0,
    ST_R    = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic [31:0] r_redir_pc;
  logic [31:0] w_redir_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic        w_unused;

  // The response code carries no information this unit acts on.
  assign w_unused    = ^mem_rresp;

  assign mem_arvalid = (r_state == ST_AR) & ~reset;
  assign mem_araddr  = r_fetch_pc;
  assign mem_rready  = 1'b1;
  assign out_valid   = (r_state == ST_HOLD) & ~flush;
  assign out_pc      = r_fetch_pc;
  assign out_inst    = r_inst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_AR;
      r_fetch_pc <= RESET_PC;
      r_inst     <= 32'd0;
      r_drop     <= 1'b0;
      r_redir_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_drop     <= w_drop_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_inst_nxt     = r_inst;
    w_drop_nxt     = r_drop;
    w_redir_pc_nxt = r_redir_pc;
    case (r_state)
      ST_AR: begin
        // The address must stay put until accepted, so a flush here is parked in redir_pc.
        if (flush) begin
          w_drop_nxt     = 1'b1;
          w_redir_pc_nxt = flush_pc;
        end
        if (mem_arvalid && mem_arready) begin
          w_state_nxt = ST_R;
        end
      end
      ST_R: begin
        if (mem_rvalid) begin
          if (flush) begin
            w_fetch_pc_nxt = flush_pc;
            w_drop_nxt     = 1'b0;
            w_state_nxt    = ST_AR;
          end else if (r_drop) begin
            w_fetch_pc_nxt = r_redir_pc;
            w_drop_nxt     = 1'b0;
            w_state_nxt    = ST_AR;
          end else begin
            w_inst_nxt  = mem_rdata;
            w_state_nxt = ST_HOLD;
          end
        end else if (flush) begin
          w_drop_nxt     = 1'b1;
          w_redir_pc_nxt = flush_pc;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          w_fetch_pc_nxt = flush_pc;
          w_state_nxt    = ST_AR;
        end else if (out_ready) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = ST_AR;
        end
      end
      default: begin
        w_state_nxt = ST_AR;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Bench for ysyx_23060203_ifu: directed scenarios then random traffic, all checked against a
// transaction-level model (next delivered pc, flush retargets, memory contents as a function of address).
module tb_ysyx_23060203_ifu;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  ysyx_23060203_ifu #(.RESET_PC(RST_PC)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .mem_araddr (mem_araddr),
    .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready),
    .mem_rdata  (mem_rdata),
    .mem_rresp  (mem_rresp),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          deliveries = 0;
  logic [31:0] model_pc = RST_PC;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  int          rd_delay = 0;
  int          lat = 0;
  logic        rand_lat = 1'b0;
  logic        force_rv = 1'b0;
  logic        s_arv;
  logic        s_ov;
  logic [31:0] s_ara;
  logic [31:0] s_opc;
  logic [31:0] s_oinst;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0013;
    if (a == 32'h8000_0000) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One clock: drive after the falling edge, sample 1ns later, then advance the memory responder and the model.
  task automatic cyc(input logic ar, input logic fl, input logic [31:0] fpc, input logic ordy);
    logic [31:0] r;
    @(negedge clock);
    mem_arready = ar;
    flush       = fl;
    flush_pc    = fpc;
    out_ready   = ordy;
    mem_rvalid  = (rd_pending && rd_delay == 0) || force_rv;
    mem_rdata   = memf(rd_addr);
    r           = $urandom;
    mem_rresp   = r[1:0];
    #1;
    s_arv   = mem_arvalid;
    s_ara   = mem_araddr;
    s_ov    = out_valid;
    s_opc   = out_pc;
    s_oinst = out_inst;
    chk1("single_outstanding", s_arv & rd_pending, 1'b0);
    if (fl) chk1("flush_masks_valid", s_ov, 1'b0);
    if (s_ov && ordy) begin
      chk("deliver_pc", s_opc, model_pc);
      chk("deliver_inst", s_oinst, memf(model_pc));
      model_pc = model_pc + 32'd4;
      deliveries++;
    end
    if (fl) model_pc = fpc;
    if (mem_rvalid) rd_pending = 1'b0;
    else if (rd_pending) rd_delay--;
    if (s_arv && ar) begin
      rd_pending = 1'b1;
      rd_addr    = s_ara;
      rd_delay   = rand_lat ? int'($urandom_range(0, 3)) : lat;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] r2;
    int          base;
    reset = 1'b1; flush = 1'b0; flush_pc = 32'd0; mem_arready = 1'b0;
    mem_rdata = 32'd0; mem_rresp = 2'd0; mem_rvalid = 1'b0; out_ready = 1'b0;

    @(negedge clock); #1;
    chk1("rst_arvalid", mem_arvalid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_araddr", mem_araddr, RST_PC);
    chk("rst_out_pc", out_pc, RST_PC);
    chk("rst_out_inst", out_inst, 32'd0);
    chk1("rst_rready", mem_rready, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    // Basic fetch: AR in cycle 1, response in cycle 2, delivery in cycle 3, next AR in cycle 4.
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("c1_arvalid", s_arv, 1'b1);
    chk("c1_araddr", s_ara, 32'h3000_0000);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("c2_out_valid", s_ov, 1'b0);
    chk1("c2_arvalid", s_arv, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("c3_out_valid", s_ov, 1'b1);
    chk("c3_out_pc", s_opc, 32'h3000_0000);
    chk("c3_out_inst", s_oinst, 32'h0000_0013);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk1("c4_arvalid", s_arv, 1'b1);
    chk("c4_araddr", s_ara, 32'h3000_0004);

    // Backpressure in ST_HOLD.
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b0);
      chk1("bp_out_valid", s_ov, 1'b1);
      chk("bp_out_pc", s_opc, 32'h3000_0004);
      chk("bp_out_inst", s_oinst, memf(32'h3000_0004));
      chk1("bp_no_ar", s_arv, 1'b0);
    end
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("bp_accept", s_ov, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk1("bp_next_arvalid", s_arv, 1'b1);
    chk("bp_next_araddr", s_ara, 32'h3000_0008);

    // Flush while holding.
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b1, 32'h8000_0000, 1'b1);
    chk1("hold_flush_valid", s_ov, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk1("hold_flush_arvalid", s_arv, 1'b1);
    chk("hold_flush_araddr", s_ara, 32'h8000_0000);

    // Flush while AR is stalled: address stays, response is dropped, then redirect.
    cyc(1'b0, 1'b1, 32'h8000_0100, 1'b0);
    chk("ar_stall_addr2", s_ara, 32'h8000_0000);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("ar_stall_addr3", s_ara, 32'h8000_0000);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("ar_stall_accept", s_ara, 32'h8000_0000);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("ar_drop_no_valid", s_ov, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("ar_redir_arvalid", s_arv, 1'b1);
    chk("ar_redir_araddr", s_ara, 32'h8000_0100);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("ar_redir_out_pc", s_opc, 32'h8000_0100);

    // Flush coincident with rvalid.
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk("rf_araddr", s_ara, 32'h8000_0104);
    cyc(1'b1, 1'b1, 32'h8000_0200, 1'b0);
    chk1("rf_no_valid", s_ov, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk("rf_redir_araddr", s_ara, 32'h8000_0200);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("rf_deliver_valid", s_ov, 1'b1);
    chk("rf_deliver_pc", s_opc, 32'h8000_0200);

    // PC wrap.
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk("wrap_araddr_top", s_ara, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap_out_pc", s_opc, 32'hFFFF_FFFC);
    lat = 5;
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk1("wrap_arvalid", s_arv, 1'b1);
    chk("wrap_araddr_zero", s_ara, 32'h0000_0000);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk1("inR_arvalid", s_arv, 1'b0);

    // Asynchronous reset pulse while a read is outstanding, with no clock edge in between.
    @(negedge clock);
    mem_arready = 1'b0; mem_rvalid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk1("arst_arvalid", mem_arvalid, 1'b0);
    chk1("arst_out_valid", out_valid, 1'b0);
    chk("arst_araddr", mem_araddr, RST_PC);
    chk("arst_out_inst", out_inst, 32'd0);
    reset = 1'b0;
    #1;
    chk1("arst_release_arvalid", mem_arvalid, 1'b1);
    rd_pending = 1'b0;
    model_pc = RST_PC;
    lat = 0;
    force_rv = 1'b1;
    rd_addr = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      chk1("stray_rv_arvalid", s_arv, 1'b1);
      chk("stray_rv_araddr", s_ara, RST_PC);
      chk1("stray_rv_out_valid", s_ov, 1'b0);
    end
    force_rv = 1'b0;
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk1("post_rst_valid", s_ov, 1'b1);
    chk("post_rst_inst", s_oinst, 32'h0000_0013);

    // Random traffic against the model.
    rand_lat = 1'b1;
    base = deliveries;
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom;
      r2 = $urandom;
      cyc(r[5:4] != 2'd0, r[3:0] == 4'd0, {r2[31:2], 2'b00}, r[6] | r[7]);
    end
    chk1("random_progress", (deliveries - base) >= 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
